dram_arbiter: RTL
=================

DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of requesters sharing the DRAM master port.
REQ-002 Parameter ADDR_WIDTH, default 32: request address width.
REQ-003 Parameter DATA_WIDTH, default 32: write/read data width.
REQ-004 Port clk  in  1: clock; all logic on rising edge.
REQ-005 Port rst_n  in  1: reset, synchronous, active-low.
REQ-006 Port req_valid  in  NUM_REQ: per-requester command valid.
REQ-007 Port req_ready  out  NUM_REQ: per-requester command accepted (one-hot or zero).
REQ-008 Port req_we  in  NUM_REQ: per-requester write(1)/read(0).
REQ-009 Port req_addr  in  NUM_REQ*ADDR_WIDTH: packed addresses, requester i at slice i.
REQ-010 Port req_wdata  in  NUM_REQ*DATA_WIDTH: packed write data, requester i at slice i.
REQ-011 Port rsp_valid  out  NUM_REQ: one-cycle completion pulse to the owning requester.
REQ-012 Port rsp_rdata  out  DATA_WIDTH: read data, valid with rsp_valid; shared by all requesters.
REQ-013 Ports m_valid/m_we/m_addr/m_wdata  out  1/1/ADDR_WIDTH/DATA_WIDTH: command to AXI master engine.
REQ-014 Port m_ready  in  1: master engine accepts command.
REQ-015 Ports m_rsp_valid/m_rsp_rdata  in  1/DATA_WIDTH: write-response or read-data completion from engine.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT_RSP; exactly one transaction outstanding.
REQ-017 IDLE: if any req_valid, select winner by round-robin starting at (last_grant+1) mod NUM_REQ; assert req_ready[winner] combinationally that cycle; capture we/addr/wdata and owner index; go to ISSUE.
REQ-018 ISSUE: m_valid=1 with captured command, held stable until m_valid&&m_ready; then go to WAIT_RSP.
REQ-019 WAIT_RSP: on m_rsp_valid, register rsp_rdata<=m_rsp_rdata, pulse rsp_valid[owner] next cycle for exactly one cycle, update last_grant<=owner, go to IDLE.
REQ-020 Minimum latency req accept to rsp_valid: 3 cycles (m_ready and m_rsp_valid each high on first opportunity).
REQ-021 rsp_rdata holds its last value until the next completion; write completions load m_rsp_rdata.
REQ-022 m_rsp_valid outside WAIT_RSP is ignored; m_ready outside ISSUE is ignored.
REQ-023 A requester deasserting req_valid before grant loses nothing; no command captured for it.
REQ-024 Single active requester is granted on every IDLE visit (no idle bubble beyond FSM return).
REQ-025 Round-robin pointer wraps from NUM_REQ-1 to 0; no requester waits more than NUM_REQ-1 grants.

Reset
REQ-026 Reset: state IDLE, last_grant=NUM_REQ-1 (requester 0 first), req_ready=0, rsp_valid=0, m_valid=0, m_we=0, m_addr=0, m_wdata=0, rsp_rdata=0.
REQ-027 Reset mid-transaction abandons it; no rsp_valid is produced for the aborted command.

Configuration
REQ-028 Macro DRAM_ARB_PERF_EN defined: add output grant_cnt (NUM_REQ*16), per-requester 16-bit saturating count of accepted commands, cleared by reset.
REQ-029 Macro DRAM_ARB_PERF_EN undefined: grant_cnt port and counters absent; all other behaviour identical.

Structure
REQ-030 Shared package gpu_mem_pkg holds arb_state_t enum and constants ARB_NUM_REQ_DEFAULT=3, PERF_CNT_WIDTH=16.
REQ-031 Sub-module rr_arbiter (combinational round-robin pick from request vector and pointer, outputs one-hot grant and index) is instantiated once.

Verification
REQ-032 After reset, req_valid=3'b111 -> grants in order 0,1,2,0; each req_ready one-cycle one-hot.
REQ-033 Req1 read addr 0x100, m_ready=1, m_rsp_valid with 0xDEADBEEF next cycle -> rsp_valid=3'b010 with rsp_rdata=0xDEADBEEF, 3 cycles after accept.
REQ-034 Req2 write addr 0x200 data 0x12345678, m_ready low 5 cycles -> m_valid/m_addr/m_wdata stable all 5 cycles, m_we=1.
REQ-035 rst_n low during WAIT_RSP of req0 -> no rsp_valid, next grant goes to req0 when all request.
REQ-036 Spurious m_rsp_valid in IDLE -> no rsp_valid pulse, rsp_rdata unchanged.
REQ-037 With DRAM_ARB_PERF_EN, 70000 req0 grants -> grant_cnt slice 0 saturates at 0xFFFF.

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the GPU memory-side arbitration blocks.
//   arb_state_t          : DRAM arbiter FSM state encoding
//   ARB_NUM_REQ_DEFAULT  : default number of requesters on the DRAM port
//   PERF_CNT_WIDTH       : width of each per-requester grant counter
package gpu_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_ISSUE    = 2'd1,
    ARB_WAIT_RSP = 2'd2
  } arb_state_t;

  localparam int ARB_NUM_REQ_DEFAULT = 3;
  localparam int PERF_CNT_WIDTH      = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req_i     : request vector
//   ptr_i     : index with highest priority this cycle
//   gnt_o     : one-hot grant (zero when no request)
//   gnt_idx_o : index of the granted requester
//   gnt_any_o : at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_any_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan starting at ptr_i and wrapping; first active request wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    cand      = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_idx_o    = cand;
        gnt_o[cand]  = 1'b1;
      end
    end
    gnt_any_o = found;
  end

endmodule

// File: rtl/dram_arbiter.sv
// DRAM command arbiter: shares one AXI master command port among NUM_REQ
// requesters, one transaction outstanding at a time, round-robin fairness.
// Ports:
//   clk, rst_n                         : clock, synchronous active-low reset
//   req_valid/req_ready/req_we         : per-requester command handshake
//   req_addr/req_wdata                 : packed per-requester command fields
//   rsp_valid/rsp_rdata                : completion pulse to owner, shared data
//   m_valid/m_we/m_addr/m_wdata/m_ready: command to master engine
//   m_rsp_valid/m_rsp_rdata            : completion from master engine
//   grant_cnt                          : per-requester saturating grant counts,
//                                        present only with DRAM_ARB_PERF_EN
//
// state        | meaning
// ARB_IDLE     | no transaction; pick a winner and capture its command
// ARB_ISSUE    | presenting captured command until m_ready
// ARB_WAIT_RSP | command accepted; waiting for m_rsp_valid
module dram_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int NUM_REQ    = ARB_NUM_REQ_DEFAULT,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           m_valid,
  output logic                           m_we,
  output logic [ADDR_WIDTH-1:0]          m_addr,
  output logic [DATA_WIDTH-1:0]          m_wdata,
  input  logic                           m_ready,
  input  logic                           m_rsp_valid,
  input  logic [DATA_WIDTH-1:0]          m_rsp_rdata
`ifdef DRAM_ARB_PERF_EN
  ,
  output logic [NUM_REQ*PERF_CNT_WIDTH-1:0] grant_cnt
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_t state_q, state_d;

  logic [IDX_W-1:0]      last_grant_q, owner_q, rr_start, rr_idx;
  logic [NUM_REQ-1:0]    rr_gnt, rsp_valid_q;
  logic                  rr_any, accept, complete;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rsp_rdata_q;

  assign rr_start = (last_grant_q == LAST_IDX) ? '0 : last_grant_q + 1'b1;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i     (req_valid),
    .ptr_i     (rr_start),
    .gnt_o     (rr_gnt),
    .gnt_idx_o (rr_idx),
    .gnt_any_o (rr_any)
  );

  assign accept   = (state_q == ARB_IDLE) && rr_any;
  assign complete = (state_q == ARB_WAIT_RSP) && m_rsp_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:     if (rr_any)      state_d = ARB_ISSUE;
      ARB_ISSUE:    if (m_ready)     state_d = ARB_WAIT_RSP;
      ARB_WAIT_RSP: if (m_rsp_valid) state_d = ARB_IDLE;
      default:                       state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ARB_IDLE) ? rr_gnt : '0;
    m_valid   = (state_q == ARB_ISSUE);
  end

  // The pointer advances on completion, not on grant, so an aborted
  // transaction leaves fairness untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= LAST_IDX;
      owner_q      <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsp_rdata_q  <= '0;
      rsp_valid_q  <= '0;
    end else begin
      rsp_valid_q <= '0;
      if (accept) begin
        owner_q <= rr_idx;
        we_q    <= req_we[rr_idx];
        addr_q  <= req_addr[rr_idx*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_q <= req_wdata[rr_idx*DATA_WIDTH +: DATA_WIDTH];
      end
      if (complete) begin
        rsp_rdata_q  <= m_rsp_rdata;
        rsp_valid_q  <= NUM_REQ'(1) << owner_q;
        last_grant_q <= owner_q;
      end
    end
  end

  assign m_we      = we_q;
  assign m_addr    = addr_q;
  assign m_wdata   = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef DRAM_ARB_PERF_EN
  logic [PERF_CNT_WIDTH-1:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt[i*PERF_CNT_WIDTH +: PERF_CNT_WIDTH] = cnt_q[i];
    end
  end
`endif

endmodule
